// File: rtl/uart_tx_core_if.sv
// uart_tx_core_if: parallel request side and serial/status side of the UART transmitter
interface uart_tx_core_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  DATA_VALID;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  TX_OUT;
    logic                  busy;
    logic                  buf_full;

    modport master (
        output P_DATA, DATA_VALID, PAR_EN, PAR_TYP,
        input  TX_OUT, busy, buf_full
    );

    modport slave (
        input  P_DATA, DATA_VALID, PAR_EN, PAR_TYP,
        output TX_OUT, busy, buf_full
    );
endinterface

// File: rtl/uart_tx_core.sv
// uart_tx_core: one-bit-per-clock UART frame serializer (start, LSB-first data, optional parity, stop); UART_TX_HOLD_BUF_EN adds a one-entry holding buffer
module uart_tx_core #(
    parameter int DATA_WIDTH = 8
) (
    input logic           clk,
    input logic           rst_n,
    uart_tx_core_if.slave bus
);
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t                r_state, w_next;
    logic [CW-1:0]         r_cnt, w_cnt_next;
    logic [DATA_WIDTH-1:0] r_shift, w_shift_next;
    logic                  r_par_en, w_par_en_next;
    logic                  r_par, w_par_next;
    logic                  r_tx, w_tx_next;
    logic                  r_busy, w_busy_next;
    logic                  w_in_par;
    logic                  w_handoff;
    logic [DATA_WIDTH-1:0] w_buf_data;
    logic                  w_buf_pe;
    logic                  w_buf_par;

    assign w_in_par   = ^bus.P_DATA ^ bus.PAR_TYP;
    assign bus.TX_OUT = r_tx;
    assign bus.busy   = r_busy;

`ifdef UART_TX_HOLD_BUF_EN
    logic                  r_buf_full;
    logic [DATA_WIDTH-1:0] r_buf_data;
    logic                  r_buf_pe;
    logic                  r_buf_par;
    logic                  w_capture;

    assign w_handoff    = (r_state == S_STOP) && r_buf_full;
    assign w_capture    = bus.DATA_VALID && r_busy && (!r_buf_full || w_handoff);
    assign w_buf_data   = r_buf_data;
    assign w_buf_pe     = r_buf_pe;
    assign w_buf_par    = r_buf_par;
    assign bus.buf_full = r_buf_full;

    // Capture a request arriving mid-frame; a hand-off frees the slot on the same edge it may be refilled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf_full <= 1'b0;
            r_buf_data <= '0;
            r_buf_pe   <= 1'b0;
            r_buf_par  <= 1'b0;
        end else if (w_capture) begin
            r_buf_full <= 1'b1;
            r_buf_data <= bus.P_DATA;
            r_buf_pe   <= bus.PAR_EN;
            r_buf_par  <= w_in_par;
        end else if (w_handoff) begin
            r_buf_full <= 1'b0;
        end
    end
`else
    assign w_handoff    = 1'b0;
    assign w_buf_data   = '0;
    assign w_buf_pe     = 1'b0;
    assign w_buf_par    = 1'b0;
    assign bus.buf_full = 1'b0;
`endif

    // Next state plus the line/busy values for the next cycle, so both outputs leave a flop together
    always_comb begin
        w_next        = r_state;
        w_cnt_next    = r_cnt;
        w_shift_next  = r_shift;
        w_par_en_next = r_par_en;
        w_par_next    = r_par;
        w_tx_next     = 1'b1;
        w_busy_next   = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_busy_next = 1'b0;
                if (bus.DATA_VALID) begin
                    w_next        = S_START;
                    w_tx_next     = 1'b0;
                    w_busy_next   = 1'b1;
                    w_shift_next  = bus.P_DATA;
                    w_par_en_next = bus.PAR_EN;
                    w_par_next    = w_in_par;
                end
            end
            S_START: begin
                w_next       = S_DATA;
                w_cnt_next   = '0;
                w_tx_next    = r_shift[0];
                w_shift_next = r_shift >> 1;
            end
            S_DATA: begin
                if (r_cnt == LAST) begin
                    w_next    = r_par_en ? S_PARITY : S_STOP;
                    w_tx_next = r_par_en ? r_par : 1'b1;
                end else begin
                    w_cnt_next   = r_cnt + 1'b1;
                    w_tx_next    = r_shift[0];
                    w_shift_next = r_shift >> 1;
                end
            end
            S_PARITY: w_next = S_STOP;
            S_STOP: begin
                if (w_handoff) begin
                    w_next        = S_START;
                    w_tx_next     = 1'b0;
                    w_shift_next  = w_buf_data;
                    w_par_en_next = w_buf_pe;
                    w_par_next    = w_buf_par;
                end else begin
                    w_next      = S_IDLE;
                    w_busy_next = 1'b0;
                end
            end
            default: begin
                w_next      = S_IDLE;
                w_busy_next = 1'b0;
            end
        endcase
    end

    // Frame state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_shift  <= '0;
            r_par_en <= 1'b0;
            r_par    <= 1'b0;
            r_tx     <= 1'b1;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_cnt    <= w_cnt_next;
            r_shift  <= w_shift_next;
            r_par_en <= w_par_en_next;
            r_par    <= w_par_next;
            r_tx     <= w_tx_next;
            r_busy   <= w_busy_next;
        end
    end
endmodule

// File: tb/tb_uart_tx_core.sv
// tb_uart_tx_core: directed scoreboard bench; every cycle the line and busy are checked against queued expected bits (UART_TX_HOLD_BUF_EN selects the buffer scenario)
module tb_uart_tx_core;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    logic q[$];

    uart_tx_core_if #(.DATA_WIDTH(8)) bus ();

    uart_tx_core #(.DATA_WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic cmp(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check();
        logic et, eb;
        if (q.size() > 0) begin
            et = q.pop_front();
            eb = 1'b1;
        end else begin
            et = 1'b1;
            eb = 1'b0;
        end
        cmp("tx", bus.TX_OUT, et);
        cmp("busy", bus.busy, eb);
`ifndef UART_TX_HOLD_BUF_EN
        cmp("buf_full", bus.buf_full, 1'b0);
`endif
    endtask

    task automatic tick();
        @(negedge clk);
        check();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic push_frame(input logic [7:0] d, input logic pe, input logic pt);
        q.push_back(1'b0);
        for (int i = 0; i < 8; i++) q.push_back(d[i]);
        if (pe) q.push_back(^d ^ pt);
        q.push_back(1'b1);
    endtask

    task automatic send(input logic [7:0] d, input logic pe, input logic pt);
        bus.P_DATA     = d;
        bus.PAR_EN     = pe;
        bus.PAR_TYP    = pt;
        bus.DATA_VALID = 1'b1;
        push_frame(d, pe, pt);
        tick();
        bus.DATA_VALID = 1'b0;
    endtask

    initial begin
        bus.P_DATA     = '0;
        bus.DATA_VALID = 1'b0;
        bus.PAR_EN     = 1'b0;
        bus.PAR_TYP    = 1'b0;
        tick();
        cmp("rst_buf_full", bus.buf_full, 1'b0);
        rst_n = 1'b1;
        run(2);

        send(8'hA5, 1'b1, 1'b0);
        run(12);

        send(8'h00, 1'b1, 1'b1);
        run(12);

        send(8'h3C, 1'b0, 1'b0);
        run(3);
        bus.P_DATA = 8'hFF;
        run(8);

`ifndef UART_TX_HOLD_BUF_EN
        send(8'h96, 1'b0, 1'b0);
        run(4);
        bus.P_DATA     = 8'h55;
        bus.DATA_VALID = 1'b1;
        tick();
        bus.DATA_VALID = 1'b0;
        run(6);

        send(8'h0F, 1'b1, 1'b1);
        for (int i = 0; i < 20 && q.size() > 0; i++) tick();
        bus.P_DATA     = 8'hF0;
        bus.PAR_EN     = 1'b0;
        bus.DATA_VALID = 1'b1;
        tick();
        push_frame(8'hF0, 1'b0, 1'b0);
        tick();
        bus.DATA_VALID = 1'b0;
        run(11);
`else
        send(8'h81, 1'b0, 1'b0);
        bus.P_DATA     = 8'h7E;
        bus.DATA_VALID = 1'b1;
        push_frame(8'h7E, 1'b0, 1'b0);
        tick();
        bus.DATA_VALID = 1'b0;
        cmp("buf_set", bus.buf_full, 1'b1);
        bus.P_DATA     = 8'h11;
        bus.DATA_VALID = 1'b1;
        tick();
        bus.DATA_VALID = 1'b0;
        cmp("buf_hold", bus.buf_full, 1'b1);
        run(7);
        cmp("buf_at_stop", bus.buf_full, 1'b1);
        tick();
        cmp("buf_clear", bus.buf_full, 1'b0);
        run(12);
`endif

        send(8'hC3, 1'b1, 1'b0);
        run(5);
        #2 rst_n = 1'b0;
        #1;
        cmp("arst_tx", bus.TX_OUT, 1'b1);
        cmp("arst_busy", bus.busy, 1'b0);
        cmp("arst_buf_full", bus.buf_full, 1'b0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        check();
        run(1);
        send(8'h5A, 1'b1, 1'b1);
        run(13);

        cmp("queue_drained", q.size() == 0, 1'b1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_tx_core.md
Name: uart_tx_core

Overview:
- Complete UART transmitter: frame FSM, shift serializer, parity generator and output mux in one block.
- Transmits one bit per clk cycle. clk is the already-divided TX baud clock from the system clock divider.
- Counterpart of the UART receive path. Frame format is identical: start, DATA_WIDTH data bits LSB first, optional parity, one stop bit.
- Fed from the system controller's TX data path. DATA_VALID and P_DATA arrive synchronised to clk.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame. Legal range 5..9.

Ports:
- clk  input  1  TX bit clock. Every register is rising-edge.
- rst_n  input  1  Asynchronous reset, active-low.
- P_DATA  input  DATA_WIDTH  Parallel word to transmit.
- DATA_VALID  input  1  Request to send P_DATA. Sampled every cycle.
- PAR_EN  input  1  1 = append a parity bit.
- PAR_TYP  input  1  0 = even parity, 1 = odd parity.
- TX_OUT  output  1  Serial line. Idle level is 1. Registered.
- busy  output  1  High while a frame is on the line. Registered.
- buf_full  output  1  Holding buffer occupied. Constant 0 unless the optional feature is compiled in.

Behaviour:
- Reset (asynchronous, any state): TX_OUT=1, busy=0, buf_full=0, state=IDLE, bit counter=0, shift and holding registers cleared.
- FSM states and transitions:
  - IDLE: waits for a request.
  - START: lasts 1 cycle.
  - DATA: lasts DATA_WIDTH cycles.
  - PARITY: lasts 1 cycle, entered only if the latched PAR_EN=1.
  - STOP: lasts 1 cycle, then returns to IDLE.
- Acceptance:
  - A request is accepted when state==IDLE and DATA_VALID==1.
  - On acceptance, P_DATA, PAR_EN and PAR_TYP are latched. Later input changes do not affect the frame in flight.
  - In the cycle after acceptance: state=START, TX_OUT=0, busy=1. Acceptance-to-start-bit latency is 1 cycle.
- DATA state:
  - TX_OUT = shift register bit 0. The register shifts right each cycle.
  - Bit counter increments from 0 and leaves DATA when it reaches DATA_WIDTH-1.
- Parity:
  - Computed once at acceptance as XOR-reduce(P_DATA) XOR PAR_TYP.
  - The PARITY state drives this value on TX_OUT.
- STOP: TX_OUT=1, busy=1.
- Return to IDLE: TX_OUT=1, busy=0.
- Back-to-back requests (no buffer): a new frame may be accepted in the first IDLE cycle. Minimum gap between stop bit and next start bit is 1 idle cycle.
- Frame length with busy high: DATA_WIDTH+2 cycles, plus 1 if PAR_EN.
- DATA_VALID while busy=1: ignored and lost (no buffer). Caller must wait for busy=0.
- TX_OUT and busy change on the same clock edge. No combinational path from any input to any output.
- Illegal state encodings recover to IDLE with TX_OUT=1.

Optional Feature:
- Macro: UART_TX_HOLD_BUF_EN.
- Defined: adds a one-entry holding register holding data, PAR_EN and PAR_TYP.
  - DATA_VALID while busy=1 and buf_full=0 captures the request and sets buf_full=1 on the next edge.
  - In STOP with buf_full=1, the next state is START directly, using the buffer contents. There is no idle cycle and busy stays 1.
  - buf_full clears on the edge entering that START.
  - DATA_VALID while buf_full=1 is dropped.
  - If DATA_VALID is high in the same cycle that STOP hands off the buffer, the new request is captured (buffer is freed and refilled on the same edge).
- Undefined: no buffer logic. buf_full is tied 0 and behaviour is exactly as in Behaviour.

Test Plan:
- Reset, then P_DATA=0xA5, PAR_EN=1, PAR_TYP=0, DATA_VALID pulse 1 cycle -> TX_OUT over the next 11 cycles = 0,1,0,1,0,0,1,0,1,0,1. busy high for exactly those 11 cycles. TX_OUT=1 after.
- P_DATA=0x00, PAR_EN=1, PAR_TYP=1 -> parity bit=1. Frame = 0,0,0,0,0,0,0,0,0,1,1.
- P_DATA=0x3C, PAR_EN=0 -> 10-cycle frame 0,0,0,1,1,1,1,0,0,1. P_DATA changed to 0xFF mid-frame has no effect.
- Second DATA_VALID (0x55) asserted during data bit 3 of a frame, macro undefined -> ignored. Only one frame sent. Next frame accepted no earlier than the first IDLE cycle.
- rst_n pulled low during data bit 4 -> TX_OUT=1 and busy=0 immediately (asynchronous). After release, a fresh request produces a full, correct frame.
- Macro defined: send 0x81 then 0x7E while busy (PAR_EN=0) -> buf_full=1 on the next edge. The second start bit follows the first stop bit with no idle cycle. busy high for 20 consecutive cycles. A third request during buf_full=1 is dropped.
